// File: rtl/mem_banked.sv
// Banked word store: NUM_BANKS sync-read RAM banks behind one flat address, valid/ready
// requests, a zeroing sweep engine, and an optional rd output stage (MEM_BANKED_OUTREG_EN).

module mem_banked_bank #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             we_i,
   input  logic             re_i,
   input  logic [AW-1:0]    addr_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // Array itself carries no reset so it maps onto block RAM.
   always_ff @(posedge clock) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
   end

   // Read port only updates on a read, so the last read value is held.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n)    rdata_q <= '0;
      else if (re_i) rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;
endmodule

module mem_banked #(
   parameter int WIDTH         = 8,
   parameter int BANK_DEPTH    = 64,
   parameter int NUM_BANKS     = 42,
   parameter int ADDR_W        = 17,
   parameter int INIT_ON_RESET = 1
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [WIDTH-1:0]  req_data,
   output logic              rd_valid,
   output logic [WIDTH-1:0]  rd_data,
   output logic              err,
   input  logic              init_start,
   output logic              busy
);
   localparam int OFF_W = $clog2(BANK_DEPTH);
   localparam int BANK_W = ADDR_W - OFF_W;
   localparam logic [ADDR_W:0] CAP = (ADDR_W+1)'(NUM_BANKS * BANK_DEPTH);

   typedef enum logic {RUN, CLEAR} state_e;
   localparam state_e RST_STATE = (INIT_ON_RESET != 0) ? CLEAR : RUN;

   state_e            state_q, state_d;
   logic [OFF_W-1:0]  clr_cnt_q, clr_cnt_d;
   logic              clearing, accept, in_range;
   logic [BANK_W-1:0] bank_idx;
   logic [OFF_W-1:0]  offset;
   logic [OFF_W-1:0]  bank_addr;
   logic [WIDTH-1:0]  bank_wdata;

   logic [NUM_BANKS-1:0][WIDTH-1:0] bank_rdata;

   // First read stage: which bank answered and whether the read was out of range
   logic              s1_vld_q, s1_err_q, s1_oor_q;
   logic [BANK_W-1:0] s1_sel_q;
   logic [WIDTH-1:0]  rd_mux;

   assign clearing  = (state_q == CLEAR);
   assign busy      = clearing;
   assign req_ready = (state_q == RUN) && !init_start;
   assign accept    = req_valid && req_ready;
   assign bank_idx  = req_addr[ADDR_W-1:OFF_W];
   assign offset    = req_addr[OFF_W-1:0];
   assign in_range  = {1'b0, req_addr} < CAP;

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = '0;
      case (state_q)
         RUN: begin
            if (init_start) state_d = CLEAR;
         end
         CLEAR: begin
            clr_cnt_d = clr_cnt_q + OFF_W'(1);
            if (clr_cnt_q == OFF_W'(BANK_DEPTH - 1)) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= RST_STATE;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   // The sweep drives every bank at once; requests cannot be accepted meanwhile.
   assign bank_addr  = clearing ? clr_cnt_q : offset;
   assign bank_wdata = clearing ? '0 : req_data;

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic hit;
      assign hit = accept && in_range && (bank_idx == BANK_W'(b));

      mem_banked_bank #(
         .WIDTH (WIDTH),
         .DEPTH (BANK_DEPTH),
         .AW    (OFF_W)
      ) u_bank (
         .clock   (clock),
         .rst_n   (rst_n),
         .we_i    (clearing || (hit && req_we)),
         .re_i    (hit && !req_we),
         .addr_i  (bank_addr),
         .wdata_i (bank_wdata),
         .rdata_o (bank_rdata[b])
      );
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_q <= 1'b0;
         s1_err_q <= 1'b0;
         s1_oor_q <= 1'b0;
         s1_sel_q <= '0;
      end else begin
         s1_vld_q <= accept && !req_we;
         s1_err_q <= accept && !in_range;
         if (accept && !req_we) begin
            s1_oor_q <= !in_range;
            s1_sel_q <= bank_idx;
         end
      end
   end

   always_comb begin
      rd_mux = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (s1_sel_q == BANK_W'(b)) rd_mux = bank_rdata[b];
      end
      if (s1_oor_q) rd_mux = '0;
   end

`ifdef MEM_BANKED_OUTREG_EN
   logic             out_vld_q, out_err_q;
   logic [WIDTH-1:0] out_data_q;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         out_vld_q  <= 1'b0;
         out_err_q  <= 1'b0;
         out_data_q <= '0;
      end else begin
         out_vld_q  <= s1_vld_q;
         out_err_q  <= s1_err_q;
         out_data_q <= rd_mux;
      end
   end

   assign rd_valid = out_vld_q;
   assign err      = out_err_q;
   assign rd_data  = out_data_q;
`else
   assign rd_valid = s1_vld_q;
   assign err      = s1_err_q;
   assign rd_data  = rd_mux;
`endif
endmodule

// File: tb/tb_mem_banked.sv
// Directed bench for mem_banked: reset sweep, reads/writes, range errors, clear, streaming.
module tb_mem_banked;
`ifdef MEM_BANKED_OUTREG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic        clock = 1'b0;
   logic        rst_n, req_valid, req_ready, req_we, rd_valid, err, init_start, busy;
   logic [16:0] req_addr;
   logic [7:0]  req_data, rd_data;
   int          checks = 0;
   int          errors = 0;

   always #5 clock = ~clock;

   mem_banked dut (
      .clock      (clock),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_data   (req_data),
      .rd_valid   (rd_valid),
      .rd_data    (rd_data),
      .err        (err),
      .init_start (init_start),
      .busy       (busy)
   );

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // One request, then wait out the read latency and return what the outputs show.
   task automatic xact(input logic we, input logic [16:0] a, input logic [7:0] wd,
                       output logic v, output logic [7:0] d, output logic e);
      req_valid = 1'b1; req_we = we; req_addr = a; req_data = wd;
      step();
      req_valid = 1'b0; req_we = 1'b0;
      repeat (LAT - 1) step();
      v = rd_valid; d = rd_data; e = err;
   endtask

   // Counts cycles until busy drops, bounded; also counts cycles where ready was high.
   task automatic count_busy(output int cnt, output int bad_ready);
      cnt = 0; bad_ready = 0;
      while (busy === 1'b1 && cnt < 200) begin
         if (req_ready !== 1'b0) bad_ready++;
         step();
         cnt++;
      end
   endtask

   task automatic test_reset();
      logic v, e; logic [7:0] d; int cnt, bad;
      rst_n = 1'b0; init_start = 1'b0; req_valid = 1'b0; req_we = 1'b0;
      req_addr = '0; req_data = '0;
      repeat (3) step();
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %0b want 0", rd_valid); end
      checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %0b want 0", err); end
      checks++; if (busy !== 1'b1 || req_ready !== 1'b0) begin errors++; $display("FAIL reset_busy_ready got %0b/%0b want 1/0", busy, req_ready); end
      rst_n = 1'b1;
      count_busy(cnt, bad);
      checks++; if (cnt != 64) begin errors++; $display("FAIL reset_sweep_len got %0d want 64", cnt); end
      checks++; if (bad != 0) begin errors++; $display("FAIL reset_sweep_ready got %0d ready cycles want 0", bad); end
      xact(1'b0, 17'd0, 8'h00, v, d, e);
      checks++; if ({v, d, e} !== {1'b1, 8'h00, 1'b0}) begin errors++; $display("FAIL reset_rd0 got v%0b d%h e%0b want v1 d00 e0", v, d, e); end
      xact(1'b0, 17'd2687, 8'h00, v, d, e);
      checks++; if ({v, d, e} !== {1'b1, 8'h00, 1'b0}) begin errors++; $display("FAIL reset_rd2687 got v%0b d%h e%0b want v1 d00 e0", v, d, e); end
   endtask

   task automatic test_write_read();
      logic v, e; logic [7:0] d;
      xact(1'b1, 17'd65, 8'hA5, v, d, e);
      checks++; if (v !== 1'b0 || e !== 1'b0) begin errors++; $display("FAIL wr65_flags got v%0b e%0b want v0 e0", v, e); end
      xact(1'b0, 17'd65, 8'h00, v, d, e);
      checks++; if ({v, d, e} !== {1'b1, 8'hA5, 1'b0}) begin errors++; $display("FAIL rd65 got v%0b d%h e%0b want v1 da5 e0", v, d, e); end
      xact(1'b0, 17'd1, 8'h00, v, d, e);
      checks++; if ({v, d, e} !== {1'b1, 8'h00, 1'b0}) begin errors++; $display("FAIL rd1 got v%0b d%h e%0b want v1 d00 e0", v, d, e); end
      step();
      checks++; if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin errors++; $display("FAIL rd_hold got v%0b d%h want v0 d00", rd_valid, rd_data); end
   endtask

   task automatic test_out_of_range();
      logic v, e; logic [7:0] d;
      xact(1'b1, 17'd2688, 8'h77, v, d, e);
      checks++; if (v !== 1'b0 || e !== 1'b1) begin errors++; $display("FAIL oor_wr got v%0b e%0b want v0 e1", v, e); end
      xact(1'b0, 17'd65, 8'h00, v, d, e);
      checks++; if (d !== 8'hA5) begin errors++; $display("FAIL oor_pre_rd got %h want a5", d); end
      xact(1'b0, 17'd2688, 8'h00, v, d, e);
      checks++; if ({v, d, e} !== {1'b1, 8'h00, 1'b1}) begin errors++; $display("FAIL oor_rd got v%0b d%h e%0b want v1 d00 e1", v, d, e); end
      step();
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL oor_err_pulse got %0b want 0", err); end
      xact(1'b0, 17'd0, 8'h00, v, d, e);
      checks++; if ({v, d, e} !== {1'b1, 8'h00, 1'b0}) begin errors++; $display("FAIL oor_rd0 got v%0b d%h e%0b want v1 d00 e0", v, d, e); end
      xact(1'b0, 17'd2687, 8'h00, v, d, e);
      checks++; if ({v, d, e} !== {1'b1, 8'h00, 1'b0}) begin errors++; $display("FAIL oor_rd2687 got v%0b d%h e%0b want v1 d00 e0", v, d, e); end
   endtask

   task automatic test_back_to_back();
      req_valid = 1'b1; req_we = 1'b1; req_addr = 17'd200; req_data = 8'hC3;
      step();
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL b2b_wr_novalid got %0b want 0", rd_valid); end
      req_we = 1'b0;
      step();
      req_valid = 1'b0;
      repeat (LAT - 1) step();
      checks++; if (rd_valid !== 1'b1 || rd_data !== 8'hC3) begin errors++; $display("FAIL b2b_rd200 got v%0b d%h want v1 dc3", rd_valid, rd_data); end
   endtask

   task automatic test_clear();
      logic v, e; logic [7:0] d; int cnt, bad;
      xact(1'b1, 17'd100, 8'h3C, v, d, e);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 17'd100;
      step();
      req_valid = 1'b0; init_start = 1'b1;
      #1;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL clr_ready_drop got %0b want 0", req_ready); end
      if (LAT == 1) begin v = rd_valid; d = rd_data; end
      step();
      init_start = 1'b0;
      if (LAT == 2) begin v = rd_valid; d = rd_data; end
      checks++; if (v !== 1'b1 || d !== 8'h3C) begin errors++; $display("FAIL clr_inflight got v%0b d%h want v1 d3c", v, d); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL clr_busy got %0b want 1", busy); end
      count_busy(cnt, bad);
      checks++; if (cnt != 64) begin errors++; $display("FAIL clr_len got %0d want 64", cnt); end
      xact(1'b0, 17'd100, 8'h00, v, d, e);
      checks++; if ({v, d, e} !== {1'b1, 8'h00, 1'b0}) begin errors++; $display("FAIL clr_rd100 got v%0b d%h e%0b want v1 d00 e0", v, d, e); end
      xact(1'b0, 17'd65, 8'h00, v, d, e);
      checks++; if (d !== 8'h00) begin errors++; $display("FAIL clr_rd65 got %h want 00", d); end
   endtask

   task automatic test_stream();
      int bad_ready = 0, pulses = 0, bad_data = 0, bad_valid = 0;
      for (int i = 0; i < 128; i++) begin
         req_valid = 1'b1; req_we = 1'b1; req_addr = 17'(i); req_data = 8'(i) ^ 8'h5A;
         if (req_ready !== 1'b1) bad_ready++;
         step();
      end
      req_we = 1'b0;
      for (int c = 0; c < 128 + LAT; c++) begin
         int j;
         if (c < 128) begin req_valid = 1'b1; req_addr = 17'(c); end
         else req_valid = 1'b0;
         step();
         j = c - (LAT - 1);
         if (j >= 0 && j < 128) begin
            if (rd_valid !== 1'b1) bad_valid++;
            else begin
               pulses++;
               if (rd_data !== (8'(j) ^ 8'h5A)) bad_data++;
            end
         end else if (rd_valid !== 1'b0) bad_valid++;
      end
      req_valid = 1'b0;
      checks++; if (bad_ready != 0) begin errors++; $display("FAIL stream_ready got %0d stalls want 0", bad_ready); end
      checks++; if (pulses != 128) begin errors++; $display("FAIL stream_pulses got %0d want 128", pulses); end
      checks++; if (bad_valid != 0) begin errors++; $display("FAIL stream_timing got %0d bad cycles want 0", bad_valid); end
      checks++; if (bad_data != 0) begin errors++; $display("FAIL stream_data got %0d bad words want 0", bad_data); end
   endtask

   task automatic test_reset_mid_sweep();
      logic v, e; logic [7:0] d; int cnt, bad;
      init_start = 1'b1;
      step();
      init_start = 1'b0;
      repeat (20) step();
      rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_rst_busy got %0b want 1", busy); end
      checks++; if (rd_data !== 8'h00 || rd_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out got v%0b d%h want v0 d00", rd_valid, rd_data); end
      repeat (2) step();
      rst_n = 1'b1;
      count_busy(cnt, bad);
      checks++; if (cnt != 64) begin errors++; $display("FAIL mid_rst_len got %0d want 64", cnt); end
      xact(1'b0, 17'd127, 8'h00, v, d, e);
      checks++; if ({v, d, e} !== {1'b1, 8'h00, 1'b0}) begin errors++; $display("FAIL mid_rst_rd127 got v%0b d%h e%0b want v1 d00 e0", v, d, e); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_out_of_range();
      test_back_to_back();
      test_clear();
      test_stream();
      test_reset_mid_sweep();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
